// File: rtl/elevator_call_panel.sv
// Button front-end for elevator_controller: 2-flop sync + debounce per button,
// press pulses, and call/stop lamps that are cleared when the door opens at a floor.

module elevator_call_panel_lane #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1, sync2, deb, deb_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= i_raw;
            sync2    <= sync1;
            deb_prev <= deb;
            // cnt counts consecutive cycles the synced level disagrees with deb
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_press = deb & ~deb_prev;
endmodule

module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int NUM_FLOORS      = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_FLOORS-1:0] i_btn_ext,
    input  logic [NUM_FLOORS-1:0] i_btn_int,
    input  logic                  i_btn_stop,
    input  logic [2:0]            i_current_floor,
    input  logic                  i_door,
    output logic [NUM_FLOORS-1:0] o_req_ext,
    output logic [NUM_FLOORS-1:0] o_req_int,
    output logic                  o_stop,
    output logic [NUM_FLOORS-1:0] o_lamp_ext,
    output logic [NUM_FLOORS-1:0] o_lamp_int,
    output logic                  o_lamp_stop,
    output logic                  o_any_call
);
    localparam int NUM_LANES = 2 * NUM_FLOORS + 1;

    logic [NUM_LANES-1:0] raw, press;

    assign raw = {i_btn_stop, i_btn_int, i_btn_ext};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            elevator_call_panel_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_lane (
                .i_clk  (i_clk),
                .i_rst_n(i_rst_n),
                .i_raw  (raw[g]),
                .o_press(press[g])
            );
        end
    endgenerate

    logic [NUM_FLOORS-1:0] clr, req_ext_n, req_int_n, lamp_ext_n, lamp_int_n;

    // A press on an already-lit lamp is already pending at the controller;
    // a press at the floor being served is dropped because clear wins.
    always_comb begin
        clr = '0;
        if (i_door && (i_current_floor < 3'(NUM_FLOORS))) begin
            clr[i_current_floor] = 1'b1;
        end
        req_ext_n  = press[NUM_FLOORS-1:0] & ~o_lamp_ext & ~clr;
        req_int_n  = press[2*NUM_FLOORS-1:NUM_FLOORS] & ~o_lamp_int & ~clr;
        lamp_ext_n = (o_lamp_ext | req_ext_n) & ~clr;
        lamp_int_n = (o_lamp_int | req_int_n) & ~clr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_ext   <= '0;
            o_req_int   <= '0;
            o_stop      <= 1'b0;
            o_lamp_ext  <= '0;
            o_lamp_int  <= '0;
            o_lamp_stop <= 1'b0;
            o_any_call  <= 1'b0;
        end else begin
            o_req_ext   <= req_ext_n;
            o_req_int   <= req_int_n;
            o_stop      <= press[NUM_LANES-1];
            o_lamp_ext  <= lamp_ext_n;
            o_lamp_int  <= lamp_int_n;
            o_lamp_stop <= o_lamp_stop ^ press[NUM_LANES-1];
            o_any_call  <= |{lamp_ext_n, lamp_int_n};
        end
    end
endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed + random bench for elevator_call_panel against a history-based reference model.

module tb_elevator_call_panel;
    localparam int DC = 4;

    logic       i_clk, i_rst_n;
    logic [4:0] i_btn_ext, i_btn_int;
    logic       i_btn_stop;
    logic [2:0] i_current_floor;
    logic       i_door;
    logic [4:0] o_req_ext, o_req_int, o_lamp_ext, o_lamp_int;
    logic       o_stop, o_lamp_stop, o_any_call;

    elevator_call_panel #(.DEBOUNCE_CYCLES(DC), .NUM_FLOORS(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_btn_ext(i_btn_ext), .i_btn_int(i_btn_int), .i_btn_stop(i_btn_stop),
        .i_current_floor(i_current_floor), .i_door(i_door),
        .o_req_ext(o_req_ext), .o_req_int(o_req_int), .o_stop(o_stop),
        .o_lamp_ext(o_lamp_ext), .o_lamp_int(o_lamp_int),
        .o_lamp_stop(o_lamp_stop), .o_any_call(o_any_call)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int nvec = 0, nerr = 0;

    // model: raw-sample history per button; a level is accepted once the last
    // DC synchronised samples all disagree with the accepted level
    logic [DC:0] hist [11];
    logic [10:0] m_d, m_rise;
    logic [4:0]  m_req_ext, m_req_int, m_lamp_ext, m_lamp_int;
    logic        m_stop, m_lamp_stop, m_any;

    logic [4:0] acc_req_ext, acc_req_int;
    int         cnt_stop;

    function automatic logic [22:0] outs();
        return {o_req_ext, o_req_int, o_stop, o_lamp_ext, o_lamp_int, o_lamp_stop, o_any_call};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 11; i++) hist[i] = '0;
        m_d = '0; m_rise = '0;
        m_req_ext = '0; m_req_int = '0; m_lamp_ext = '0; m_lamp_int = '0;
        m_stop = 1'b0; m_lamp_stop = 1'b0; m_any = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [10:0] raw, press;
        logic [4:0]  clr;
        logic        stable;
        @(posedge i_clk);
        raw   = {i_btn_stop, i_btn_int, i_btn_ext};
        press = m_rise;
        clr   = '0;
        if (i_door && i_current_floor <= 3'd4) clr = 5'(1 << i_current_floor);
        m_req_ext   = press[4:0] & ~m_lamp_ext & ~clr;
        m_req_int   = press[9:5] & ~m_lamp_int & ~clr;
        m_lamp_ext  = (m_lamp_ext | m_req_ext) & ~clr;
        m_lamp_int  = (m_lamp_int | m_req_int) & ~clr;
        m_stop      = press[10];
        m_lamp_stop = m_lamp_stop ^ press[10];
        m_any       = |{m_lamp_ext, m_lamp_int};
        for (int i = 0; i < 11; i++) begin
            stable = 1'b1;
            for (int k = 1; k <= DC; k++) if (hist[i][k] == m_d[i]) stable = 1'b0;
            m_rise[i] = 1'b0;
            if (stable) begin
                m_d[i]    = ~m_d[i];
                m_rise[i] = m_d[i];
            end
            hist[i] = {hist[i][DC-1:0], raw[i]};
        end
        #1;
        chk("step", outs(),
            {m_req_ext, m_req_int, m_stop, m_lamp_ext, m_lamp_int, m_lamp_stop, m_any});
        acc_req_ext |= o_req_ext;
        acc_req_int |= o_req_int;
        if (o_stop) cnt_stop++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int hold);
        #2 i_rst_n = 1'b0;
        #1 chk("rst_outs", outs(), 23'd0);
        model_clear();
        repeat (hold) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] pat;
        i_rst_n = 1'b1; i_btn_ext = '0; i_btn_int = '0; i_btn_stop = 1'b0;
        i_current_floor = '0; i_door = 1'b0;
        acc_req_ext = '0; acc_req_int = '0; cnt_stop = 0;
        model_clear();
        do_reset(3);
        run(3);

        // single cabin press: pulse exactly at edge DC+2
        i_btn_int = 5'b01000;
        run(6);
        chk("t1_pre", 23'(o_req_int), 23'd0);
        step();
        chk("t1_pulse", 23'(o_req_int), 23'b01000);
        chk("t1_lamp", 23'({o_lamp_int[3], o_any_call}), 23'b11);
        step();
        chk("t1_width", 23'(o_req_int), 23'd0);
        i_btn_int = '0; run(8);

        // short glitch rejected, bounce accepted once
        acc_req_ext = '0;
        i_btn_ext[1] = 1'b1; run(3);
        i_btn_ext[1] = 1'b0; run(10);
        chk("t2_glitch", 23'({acc_req_ext, o_lamp_ext}), 23'd0);
        pat = 7'b1111101;
        for (int k = 0; k < 7; k++) begin
            i_btn_ext[1] = pat[k];
            step();
        end
        step();
        chk("t2_bounce_pre", 23'(o_req_ext), 23'd0);
        step();
        chk("t2_bounce_pulse", 23'(o_req_ext), 23'b00010);
        i_btn_ext = '0; run(8);

        // service clear at floor 2 leaves other lamps alone
        i_btn_int = 5'b10100; run(8);
        i_btn_int = '0; run(8);
        chk("t3_lit", 23'(o_lamp_int), 23'b11100);
        i_door = 1'b1; i_current_floor = 3'd2; step();
        chk("t3_clear", 23'(o_lamp_int), 23'b11000);
        i_door = 1'b0; step();

        // repeat press on lit lamp, then press at the floor being served
        i_btn_ext[0] = 1'b1; run(8);
        i_btn_ext[0] = 1'b0; run(8);
        chk("t4_lit", 23'(o_lamp_ext), 23'b00011);
        acc_req_ext = '0;
        i_btn_ext[0] = 1'b1; run(8);
        i_btn_ext[0] = 1'b0; run(8);
        chk("t4_repeat", 23'({acc_req_ext, o_lamp_ext[0]}), 23'b000001);
        i_door = 1'b1; i_current_floor = 3'd0; acc_req_ext = '0;
        i_btn_ext[0] = 1'b1; run(10);
        chk("t4_served", 23'({acc_req_ext, o_lamp_ext[0]}), 23'd0);
        i_btn_ext[0] = 1'b0; run(8);
        i_current_floor = 3'd4; step();
        i_door = 1'b0; step();

        // simultaneous presses all pulse together
        i_btn_int = 5'b10010; i_btn_ext = 5'b10000;
        run(6); step();
        chk("t5_pulse", 23'({o_req_int, o_req_ext}), 23'b10010_10000);
        step();
        chk("t5_width", 23'({o_req_int, o_req_ext}), 23'd0);
        i_btn_int = '0; i_btn_ext = '0; run(8);

        // stop toggles
        chk("t6_stop0", 23'(o_lamp_stop), 23'd0);
        cnt_stop = 0;
        i_btn_stop = 1'b1; run(8); i_btn_stop = 1'b0; run(8);
        chk("t6_stop1", 23'(o_lamp_stop), 23'd1);
        i_btn_stop = 1'b1; run(8); i_btn_stop = 1'b0; run(8);
        chk("t6_stop2", 23'({cnt_stop[3:0], o_lamp_stop}), 23'({4'd2, 1'b0}));

        // reset mid-debounce, button released during reset
        i_btn_int[0] = 1'b1; run(3);
        i_btn_int[0] = 1'b0;
        do_reset(2);
        acc_req_int = '0; run(10);
        chk("t6_rst_nopulse", 23'(acc_req_int), 23'd0);
        // button held through reset release is a fresh press
        i_btn_int[0] = 1'b1; run(3);
        do_reset(2);
        run(6);
        chk("t6_held_pre", 23'(o_req_int), 23'd0);
        step();
        chk("t6_held_pulse", 23'(o_req_int), 23'b00001);
        i_btn_int = '0; run(8);

        // random traffic
        for (int n = 0; n < 2500; n++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 9) == 0) i_btn_ext[b] = ~i_btn_ext[b];
                if ($urandom_range(0, 9) == 0) i_btn_int[b] = ~i_btn_int[b];
            end
            if ($urandom_range(0, 11) == 0) i_btn_stop = ~i_btn_stop;
            i_door          = ($urandom_range(0, 3) == 0);
            i_current_floor = 3'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
Front-end conditioner between the raw cabin and hall push-buttons and elevator_controller. It synchronises and debounces 5 hall (external) buttons, 5 cabin (internal) buttons and the stop button. Each accepted press becomes a one-cycle request pulse on the controller's i_req_ext / i_req_inter / i_stop inputs. It also drives per-floor call lamps, which stay lit until the controller opens the door at that floor, plus a stop-mode lamp.

Parameters:
DEBOUNCE_CYCLES, 500_000, consecutive stable synchronised cycles required to accept a level change (10 ms at 50 MHz); must be >= 1
NUM_FLOORS, 5, floors served; fixed at 5 for this release, all floor vectors are 5 bits

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_btn_ext  input  5  raw hall call buttons, bit n = floor n, active high, asynchronous
i_btn_int  input  5  raw cabin floor buttons, bit n = floor n, active high, asynchronous
i_btn_stop  input  1  raw cabin stop button, active high, asynchronous
i_current_floor  input  3  floor from controller o_current_floor
i_door  input  1  door-open indication from controller o_door
o_req_ext  output  5  one-cycle request pulses to controller i_req_ext
o_req_int  output  5  one-cycle request pulses to controller i_req_inter
o_stop  output  1  one-cycle stop pulse to controller i_stop
o_lamp_ext  output  5  hall call lamps
o_lamp_int  output  5  cabin call lamps
o_lamp_stop  output  1  stop-mode lamp, toggles per accepted stop press
o_any_call  output  1  OR of o_lamp_ext and o_lamp_int

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All outputs, synchroniser flops, debounced states, edge flops and counters are 0 while reset is asserted. Reset mid-debounce discards the count. A button held through reset release is treated as a new press and is accepted after the normal debounce.
- Synchroniser: each of the 11 inputs passes through a 2-flop synchroniser. Call the synchronised value s and the debounced state d.
- Debounce, per input, with an independent counter of width $clog2(DEBOUNCE_CYCLES)+1:
  - if s == d: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: d <= s and counter <= 0.
  - else: counter <= counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles leaves d unchanged.
- Press detect: a press is d rising (d=1, and the registered previous d=0). Release events produce no output.
- Latency: take edge 0 as the first i_clk edge that samples a raw input steady high.
  - d rises at edge DEBOUNCE_CYCLES+1.
  - The output pulse and the lamp set both take effect at edge DEBOUNCE_CYCLES+2.
  - The pulse is high for exactly one cycle.
  - All outputs are registered.
- Service clear: on every edge where i_door==1 and i_current_floor<=4, o_lamp_ext[f] and o_lamp_int[f] are cleared for f=i_current_floor. If i_current_floor>4, nothing is cleared.
- Accept rules for a floor press on floor f (hall or cabin):
  - Press while the same lamp is already lit: pulse suppressed, lamp stays lit. The controller already holds that request pending.
  - Press at floor f in a cycle where i_door==1 and i_current_floor==f: pulse suppressed and lamp not set; clear wins.
  - Otherwise: pulse is emitted and the lamp is set.
  - Hall and cabin lamps for the same floor are independent. Both may be lit, and both pulses may fire in the same cycle.
- Simultaneous events:
  - Several floor presses in one cycle each produce their own pulse bit in that cycle, with no serialisation.
  - A set on floor f and a clear on floor g≠f in the same cycle both take effect.
- Stop: each accepted stop press emits a one-cycle o_stop and toggles o_lamp_stop. Stop presses are never suppressed and are independent of i_door and the floor inputs.
- o_any_call is registered and equals the OR of the next lamp values, so it updates in the same cycle as the lamps.
- No FIFO or state machine beyond the per-input debounce counters and lamp flops. The controller owns request ordering.

Test Plan:
1. DEBOUNCE_CYCLES=4. Hold i_btn_int[3]=1 from edge 0 → o_req_int=5'b01000 for exactly one cycle at edge 6; o_lamp_int[3]=1 and o_any_call=1 from edge 6.
2. DEBOUNCE_CYCLES=4. Pulse i_btn_ext[1] high for 3 cycles, then low → no o_req_ext pulse and o_lamp_ext stays 0. Bounce pattern 1,0,1,1,1,1,1 → exactly one pulse, 6 edges after the final rise.
3. Lamp int[2] lit, then i_current_floor=2 and i_door=1 for one cycle → o_lamp_int[2]=0 on the next edge. o_lamp_int[4] lit at the same time stays lit.
4. Lamp ext[0] already lit, press ext[0] again → no pulse. Then with i_door=1 and i_current_floor=0 held, press ext[0] → no pulse and lamp stays 0.
5. Press int[1], int[4] and ext[4] simultaneously → o_req_int=5'b10010 and o_req_ext=5'b10000 in the same cycle, each one cycle wide.
6. Two separated stop presses → two one-cycle o_stop pulses; o_lamp_stop goes 0→1→0. Assert i_rst_n=0 mid-debounce → all outputs 0 immediately and no pulse after release unless the button is still held.
